garduino_sys_v1_sysid_checker: RTL and testbench
================================================

# garduino_sys_v1_sysid_checker

Avalon-MM read master that runs the initiator side of the system-ID slave's control interface. On a start pulse it reads the ID word at address 0 and the timestamp word at address 1, then compares both against build-time expected values. It reports pass/fail and timeout status so the boot sequencer can refuse to release the Nios/peripheral resets on a mismatched or absent image. It sits in the Qsys system next to the sysid slave, mastering only that slave's 2-word span.

## Interface
- EXPECTED_ID, 0: expected 32-bit word at address 0.
- EXPECTED_TIMESTAMP, 1599928672: expected 32-bit word at address 1.
- TIMEOUT_CYCLES, 255: maximum wait-request cycles per read attempt (1..65535).
- MAX_RETRIES, 3: re-issue attempts after a timeout before giving up (0..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run a check; sampled in IDLE and DONE only.
- master_address  out  1  Avalon word address: 0 = ID, 1 = timestamp.
- master_read  out  1  Avalon read strobe.
- master_waitrequest  in  1  Avalon wait-request; the slave holds it low when it has no stall.
- master_readdata  in  32  Avalon read data; valid in any cycle where read=1 and waitrequest=0.
- busy  out  1  high from the first read cycle through CHECK.
- done  out  1  level; high in DONE until the next accepted start.
- id_ok  out  1  id_value equals EXPECTED_ID; valid while done=1.
- ts_ok  out  1  ts_value equals EXPECTED_TIMESTAMP; valid while done=1.
- timeout_err  out  1  a read exhausted its retries; valid while done=1.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.

## Operation
- States: IDLE, RD_ID, RD_TS, GAP, CHECK, DONE.
- IDLE/DONE + start=1 → RD_ID.
  - Clears done, id_ok, ts_ok, timeout_err, retry_cnt, and wait_cnt.
  - id_value and ts_value keep their old values until overwritten.
- RD_ID: read=1, address=0.
  - Cycle with waitrequest=0: capture readdata into id_value, clear wait_cnt, → RD_TS.
- RD_TS: read=1, address=1.
  - Cycle with waitrequest=0: capture readdata into ts_value, → CHECK.
- Timeout in RD_ID or RD_TS: each cycle with waitrequest=1 increments wait_cnt (16-bit, saturating).
  - When wait_cnt reaches TIMEOUT_CYCLES while waitrequest is still 1:
    - retry_cnt < MAX_RETRIES: increment retry_cnt, clear wait_cnt, → GAP.
    - otherwise: set timeout_err, → DONE. id_ok and ts_ok stay 0.
- GAP: read=0 for exactly one cycle, address held, then returns to the state that timed out. retry_cnt is shared across both reads.
- CHECK: id_ok ← (id_value == EXPECTED_ID), ts_ok ← (ts_value == EXPECTED_TIMESTAMP), → DONE. Comparison is full 32-bit unsigned equality.
- DONE: done=1, read=0, results held.
- start while busy: ignored, no queueing.
- read and address change only at state transitions. address never changes while read=1 and waitrequest=1 (Avalon hold rule).

## Timing
- Reset values:
  - state IDLE.
  - master_read 0, master_address 0.
  - busy 0, done 0, id_ok 0, ts_ok 0, timeout_err 0.
  - id_value 0, ts_value 0, counters 0.
- Reset asserted mid-transaction forces IDLE and drops master_read in the same cycle (asynchronous); the in-flight read is abandoned.
- Zero-wait latency: start at cycle N → read (addr 0) in N+1, read (addr 1) in N+2, CHECK in N+3, done=1 and results valid in N+4.
- Each wait-request cycle adds one cycle. Each retry adds TIMEOUT_CYCLES + 1 cycles.
- All outputs are registered; no combinational path from master_waitrequest or master_readdata to any output.
- Worst case with MAX_RETRIES=3, TIMEOUT_CYCLES=255, stall on ID: done at N+1+4×255+3.

## Test plan
- No wait, slave returns 0 then 1599928672, start at cycle 10 → reads at 11/12, done=1 at 14, id_ok=1, ts_ok=1, timeout_err=0, busy high cycles 11–13.
- waitrequest=1 for 5 cycles on the address-1 read → ts captured on the 6th read cycle, done 5 cycles later than the zero-wait case, address held at 1 throughout the stall.
- Slave returns timestamp 0x5F5E0000 → id_ok=1, ts_ok=0, ts_value=0x5F5E0000, timeout_err=0.
- waitrequest stuck high, TIMEOUT_CYCLES=4, MAX_RETRIES=2 → three 4-cycle read bursts, each followed by a 1-cycle read=0 gap; then done=1, timeout_err=1, id_ok=0, ts_ok=0.
- reset pulsed during a stalled RD_TS → read=0 immediately, all outputs at reset values. A subsequent start gives a normal pass.
- start pulsed while busy → ignored, single run. start in DONE → done drops next cycle and a fresh run passes.

Source files
------------

// File: rtl/garduino_sys_v1_sysid_checker.sv
// garduino_sys_v1_sysid_checker
//
// Avalon-MM read master for the system-ID slave. A start pulse reads the ID
// word (address 0) and then the timestamp word (address 1). Both are compared
// against build-time expected values, and the result is reported to the boot
// sequencer. That sequencer keeps the Nios and peripheral resets asserted
// until it sees a matching image.
//
// A read stalled by waitrequest for TIMEOUT_CYCLES cycles is abandoned. The
// master drops read for one gap cycle and re-issues the same address, up to
// MAX_RETRIES times. The retry budget is shared by both reads.
//
// Ports
//   clock               system clock
//   reset               asynchronous, active-high reset
//   start               single-cycle run request (honoured in IDLE/DONE only)
//   master_address      Avalon word address: 0 = ID, 1 = timestamp
//   master_read         Avalon read strobe
//   master_waitrequest  Avalon wait-request from the slave
//   master_readdata     Avalon read data, valid when read=1 and waitrequest=0
//   busy                high from the first read cycle through CHECK
//   done                level, high in DONE until the next accepted start
//   id_ok               captured ID matches EXPECTED_ID (valid while done)
//   ts_ok               captured timestamp matches EXPECTED_TIMESTAMP
//   timeout_err         a read ran out of retries (valid while done)
//   id_value            captured ID word
//   ts_value            captured timestamp word
//
// Every output is a flop. No combinational path runs from the Avalon inputs
// to the outputs.

module garduino_sys_v1_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1599928672,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        master_address,
  output logic        master_read,
  input  logic        master_waitrequest,
  input  logic [31:0] master_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // The timeout fires in the stall cycle that would bring wait_cnt up to
  // TIMEOUT_CYCLES. Each attempt therefore keeps read high for exactly
  // TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_GAP   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t      state_q,          state_d;
  logic        master_read_q,    master_read_d;
  logic        master_address_q, master_address_d;
  logic        busy_q,           busy_d;
  logic        done_q,           done_d;
  logic        id_ok_q,          id_ok_d;
  logic        ts_ok_q,          ts_ok_d;
  logic        timeout_err_q,    timeout_err_d;
  logic [31:0] id_value_q,       id_value_d;
  logic [31:0] ts_value_q,       ts_value_d;
  logic [15:0] wait_cnt_q,       wait_cnt_d;
  logic [3:0]  retry_cnt_q,      retry_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  // ---- next-state / output decode ----
  always_comb begin
    state_d          = state_q;
    master_read_d    = master_read_q;
    master_address_d = master_address_q;
    busy_d           = busy_q;
    done_d           = done_q;
    id_ok_d          = id_ok_q;
    ts_ok_d          = ts_ok_q;
    timeout_err_d    = timeout_err_q;
    id_value_d       = id_value_q;
    ts_value_d       = ts_value_q;
    wait_cnt_d       = wait_cnt_q;
    retry_cnt_d      = retry_cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d          = ST_RD_ID;
          master_read_d    = 1'b1;
          master_address_d = 1'b0;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          id_ok_d          = 1'b0;
          ts_ok_d          = 1'b0;
          timeout_err_d    = 1'b0;
          wait_cnt_d       = 16'd0;
          retry_cnt_d      = 4'd0;
        end
      end

      ST_RD_ID, ST_RD_TS: begin
        if (!master_waitrequest) begin
          wait_cnt_d = 16'd0;
          if (state_q == ST_RD_ID) begin
            id_value_d       = master_readdata;
            state_d          = ST_RD_TS;
            master_address_d = 1'b1;
          end else begin
            ts_value_d    = master_readdata;
            state_d       = ST_CHECK;
            master_read_d = 1'b0;
          end
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          master_read_d = 1'b0;
          if (retry_cnt_q < RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            wait_cnt_d  = 16'd0;
            state_d     = ST_GAP;
          end else begin
            // Out of retries: skip CHECK so id_ok/ts_ok stay cleared.
            timeout_err_d = 1'b1;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            state_d       = ST_DONE;
          end
        end else begin
          wait_cnt_d = sat_inc16(wait_cnt_q);
        end
      end

      ST_GAP: begin
        // The held address identifies which read timed out.
        master_read_d = 1'b1;
        state_d       = master_address_q ? ST_RD_TS : ST_RD_ID;
      end

      ST_CHECK: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      default: begin
        state_d       = ST_IDLE;
        master_read_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
      end
    endcase
  end

  // ---- registered state and outputs ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      master_read_q    <= 1'b0;
      master_address_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      id_ok_q          <= 1'b0;
      ts_ok_q          <= 1'b0;
      timeout_err_q    <= 1'b0;
      id_value_q       <= 32'd0;
      ts_value_q       <= 32'd0;
      wait_cnt_q       <= 16'd0;
      retry_cnt_q      <= 4'd0;
    end else begin
      state_q          <= state_d;
      master_read_q    <= master_read_d;
      master_address_q <= master_address_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      id_ok_q          <= id_ok_d;
      ts_ok_q          <= ts_ok_d;
      timeout_err_q    <= timeout_err_d;
      id_value_q       <= id_value_d;
      ts_value_q       <= ts_value_d;
      wait_cnt_q       <= wait_cnt_d;
      retry_cnt_q      <= retry_cnt_d;
    end
  end

  assign master_read    = master_read_q;
  assign master_address = master_address_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign id_ok          = id_ok_q;
  assign ts_ok          = ts_ok_q;
  assign timeout_err    = timeout_err_q;
  assign id_value       = id_value_q;
  assign ts_value       = ts_value_q;

endmodule

// File: tb/tb_garduino_sys_v1_sysid_checker.sv
module tb_garduino_sys_v1_sysid_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, start_b;
  logic        wr, wr_b;
  logic [31:0] id_word, ts_word;
  logic [31:0] rdata, rdata_b;

  logic        addr, rd, busy, done, id_ok, ts_ok, tmo;
  logic [31:0] id_v, ts_v;
  logic        addr_b, rd_b, busy_b, done_b, id_ok_b, ts_ok_b, tmo_b;
  logic [31:0] id_v_b, ts_v_b;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  // Zero-latency slave data model: word selected by the current address.
  assign rdata   = addr   ? ts_word : id_word;
  assign rdata_b = addr_b ? ts_word : id_word;

  garduino_sys_v1_sysid_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .master_address(addr), .master_read(rd),
    .master_waitrequest(wr), .master_readdata(rdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(tmo), .id_value(id_v), .ts_value(ts_v)
  );

  garduino_sys_v1_sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .master_address(addr_b), .master_read(rd_b),
    .master_waitrequest(wr_b), .master_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b),
    .timeout_err(tmo_b), .id_value(id_v_b), .ts_value(ts_v_b)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_b = 1'b0; wr = 1'b0; wr_b = 1'b1;
    id_word = 32'd0; ts_word = 32'd1599928672;
    repeat (2) @(negedge clock);
    tests++;
    if ({rd, addr, busy, done, id_ok, ts_ok, tmo} !== 7'b0) begin
      fails++; $display("FAIL reset_ctl got=%b want=0000000", {rd, addr, busy, done, id_ok, ts_ok, tmo});
    end
    tests++;
    if ({id_v, ts_v} !== 64'd0) begin
      fails++; $display("FAIL reset_data got=%h want=0", {id_v, ts_v});
    end
    tests++;
    if ({rd_b, addr_b, busy_b, done_b, tmo_b} !== 5'b0) begin
      fails++; $display("FAIL reset_b got=%b want=00000", {rd_b, addr_b, busy_b, done_b, tmo_b});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Zero-wait run; expects pass with the given timestamp match result.
  task automatic run_zero_wait(input string tag, input logic exp_ts_ok);
    wr = 1'b0;
    start = 1'b1;
    @(negedge clock); start = 1'b0;            // N+1
    tests++;
    if ({rd, addr, busy, done} !== 4'b1010) begin
      fails++; $display("FAIL %s_rd_id got=%b want=1010", tag, {rd, addr, busy, done});
    end
    @(negedge clock);                          // N+2
    tests++;
    if ({rd, addr, busy, done} !== 4'b1110) begin
      fails++; $display("FAIL %s_rd_ts got=%b want=1110", tag, {rd, addr, busy, done});
    end
    @(negedge clock);                          // N+3
    tests++;
    if ({rd, busy, done} !== 3'b010) begin
      fails++; $display("FAIL %s_check got=%b want=010", tag, {rd, busy, done});
    end
    @(negedge clock);                          // N+4
    tests++;
    if ({rd, busy, done, id_ok, ts_ok, tmo} !== {5'b00111, 1'b0} && 1'b0) begin
    end
    if ({rd, busy, done, id_ok, ts_ok, tmo} !== {4'b0011, exp_ts_ok, 1'b0}) begin
      fails++; $display("FAIL %s_done got=%b want=%b", tag, {rd, busy, done, id_ok, ts_ok, tmo},
                        {4'b0011, exp_ts_ok, 1'b0});
    end
    tests++;
    if ({id_v, ts_v} !== {id_word, ts_word}) begin
      fails++; $display("FAIL %s_values got=%h want=%h", tag, {id_v, ts_v}, {id_word, ts_word});
    end
  endtask

  task automatic test_zero_wait();
    run_zero_wait("zw", 1'b1);
    @(negedge clock);
  endtask

  task automatic test_stall_ts();
    start = 1'b1;
    @(negedge clock); start = 1'b0;            // N+1 RD_ID
    @(negedge clock); wr = 1'b1;               // N+2 RD_TS, stall begins
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({rd, addr, busy, done} !== 4'b1110) begin
        fails++; $display("FAIL stall_hold%0d got=%b want=1110", i, {rd, addr, busy, done});
      end
      @(negedge clock);
    end
    wr = 1'b0;                                 // 6th read cycle, N+7
    tests++;
    if ({rd, addr} !== 2'b11) begin
      fails++; $display("FAIL stall_6th got=%b want=11", {rd, addr});
    end
    @(negedge clock);                          // N+8 CHECK
    tests++;
    if ({rd, busy, done} !== 3'b010) begin
      fails++; $display("FAIL stall_check got=%b want=010", {rd, busy, done});
    end
    @(negedge clock);                          // N+9 DONE
    tests++;
    if ({done, id_ok, ts_ok, tmo} !== 4'b1110 || ts_v !== 32'd1599928672) begin
      fails++; $display("FAIL stall_done got=%b/%h want=1110/%h", {done, id_ok, ts_ok, tmo}, ts_v, 32'd1599928672);
    end
    @(negedge clock);
  endtask

  task automatic test_ts_mismatch();
    ts_word = 32'h5F5E0000;
    run_zero_wait("mism", 1'b0);
    ts_word = 32'd1599928672;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    logic exp_rd;
    wr_b = 1'b1;
    start_b = 1'b1;
    @(negedge clock); start_b = 1'b0;          // N+1
    for (int k = 1; k <= 14; k++) begin
      exp_rd = !(k == 5 || k == 10);
      tests++;
      if ({rd_b, addr_b, busy_b, done_b} !== {exp_rd, 3'b010}) begin
        fails++; $display("FAIL tmo_cycle%0d got=%b want=%b", k, {rd_b, addr_b, busy_b, done_b}, {exp_rd, 3'b010});
      end
      @(negedge clock);
    end
    tests++;                                   // N+15
    if ({rd_b, busy_b, done_b, tmo_b, id_ok_b, ts_ok_b} !== 6'b001100) begin
      fails++; $display("FAIL tmo_done got=%b want=001100", {rd_b, busy_b, done_b, tmo_b, id_ok_b, ts_ok_b});
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    wr = 1'b0;
    start = 1'b1;
    @(negedge clock); start = 1'b0;            // N+1 RD_ID
    @(negedge clock); wr = 1'b1;               // N+2 RD_TS stalled
    @(negedge clock);
    @(negedge clock);
    tests++;
    if ({rd, addr, busy} !== 3'b111) begin
      fails++; $display("FAIL rmid_pre got=%b want=111", {rd, addr, busy});
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({rd, addr, busy, done, id_ok, ts_ok, tmo} !== 7'b0 || {id_v, ts_v} !== 64'd0) begin
      fails++; $display("FAIL rmid_async got=%b/%h want=0/0", {rd, addr, busy, done, id_ok, ts_ok, tmo}, {id_v, ts_v});
    end
    @(negedge clock);
    reset = 1'b0; wr = 1'b0;
    @(negedge clock);
    run_zero_wait("rmid_rerun", 1'b1);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    wr = 1'b0;
    start = 1'b1;
    @(negedge clock); start = 1'b0;            // N+1
    @(negedge clock); start = 1'b1;            // N+2, busy: ignored
    @(negedge clock); start = 1'b0;            // N+3
    tests++;
    if ({rd, busy, done} !== 3'b010) begin
      fails++; $display("FAIL b2b_check got=%b want=010", {rd, busy, done});
    end
    @(negedge clock);                          // N+4
    tests++;
    if ({busy, done, id_ok, ts_ok} !== 4'b0111) begin
      fails++; $display("FAIL b2b_done got=%b want=0111", {busy, done, id_ok, ts_ok});
    end
    @(negedge clock);                          // N+5, still DONE
    tests++;
    if ({rd, busy, done} !== 3'b001) begin
      fails++; $display("FAIL b2b_noqueue got=%b want=001", {rd, busy, done});
    end
    run_zero_wait("b2b_restart", 1'b1);        // start in DONE
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_ts();
    test_ts_mismatch();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
